instr_fetch_unit: RTL and testbench

- Front-end fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory address bus.
- Captures the returned instruction words into a small prefetch FIFO, tagging each with its PC.
- Hands instructions to decode over a valid/ready handshake; supports pipeline redirect (branch/jump) with flush of in-flight and buffered fetches.

---
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/instr_fetch_unit.sv | 202 ++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory address/data plus the decode handshake and redirect.
// The master modport is the fetch unit's view; the slave modport is the memory/decode environment.
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
) ();
    logic               fetch_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    modport master (
        input  fetch_en, imem_instr, redirect_valid, redirect_pc, out_ready,
        output imem_addr, out_valid, out_instr, out_pc
    );

    modport slave (
        output fetch_en, imem_instr, redirect_valid, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues addresses to instruction memory, buffers returned words with their PC.
// Optional macro FETCH_PERF_CNT_EN adds saturating perf_fetched / perf_flushed counters.
module instr_fetch_unit #(
    parameter int               ADDR_W      = 8,
    parameter int               INSTR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int               PC_STEP     = 4,
    parameter int               FIFO_DEPTH  = 4,
    parameter int               MEM_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    instr_fetch_unit_if.master        bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]               perf_fetched,
    output logic [15:0]               perf_flushed
`endif
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + MEM_LATENCY + 2);

    typedef enum logic {RUN, HOLD} state_t;

    state_t                               state_reg, state_next;
    logic [ADDR_W-1:0]                    pc_reg, pc_next;
    logic [ADDR_W-1:0]                    addr_reg, addr_next;

    logic [MEM_LATENCY-1:0]               tag_valid_reg, tag_valid_next;
    logic [MEM_LATENCY-1:0][ADDR_W-1:0]   tag_addr_reg, tag_addr_next;

    logic [INSTR_W-1:0]                   fifo_instr_reg [FIFO_DEPTH];
    logic [ADDR_W-1:0]                    fifo_pc_reg    [FIFO_DEPTH];
    logic [PTR_W-1:0]                     rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]                     wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]                     count_reg, count_next;
    logic [INSTR_W-1:0]                   head_instr_reg, head_instr_next;
    logic [ADDR_W-1:0]                    head_pc_reg, head_pc_next;
    logic                                 head_load;

    logic [CNT_W-1:0]                     inflight;
    logic [CNT_W-1:0]                     occupancy;
    logic                                 credit_ok;
    logic                                 issue;
    logic [ADDR_W-1:0]                    issue_addr;
    logic                                 push;
    logic                                 pop;
    logic                                 redirect;

    assign redirect = bus.redirect_valid;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight = inflight + CNT_W'(tag_valid_reg[i]);
        end
    end

    // Issuing only while buffered + in-flight stays below depth guarantees every return has a slot.
    assign occupancy = count_reg + inflight;
    assign credit_ok = occupancy < CNT_W'(FIFO_DEPTH);

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        issue_addr = pc_reg;
        case (state_reg)
            RUN: begin
                if (bus.fetch_en && credit_ok) begin
                    issue = 1'b1;
                end else begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.fetch_en && credit_ok) begin
                    issue      = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
        if (redirect) begin
            issue      = bus.fetch_en;
            issue_addr = bus.redirect_pc;
            state_next = RUN;
        end
    end

    always_comb begin
        pc_next   = pc_reg;
        addr_next = addr_reg;
        if (redirect) begin
            addr_next = bus.redirect_pc;
            pc_next   = bus.redirect_pc + ADDR_W'(PC_STEP);
        end else if (issue) begin
            addr_next = pc_reg;
            pc_next   = pc_reg + ADDR_W'(PC_STEP);
        end
    end

    // Tag pipe mirrors memory latency; a redirect kills everything except the new stage-0 tag.
    genvar gi;
    generate
        for (gi = 0; gi < MEM_LATENCY; gi++) begin : g_pipe
            if (gi == 0) begin : g_first
                assign tag_valid_next[gi] = issue;
                assign tag_addr_next[gi]  = issue_addr;
            end else begin : g_rest
                assign tag_valid_next[gi] = tag_valid_reg[gi-1] && !redirect;
                assign tag_addr_next[gi]  = tag_addr_reg[gi-1];
            end
        end
    endgenerate

    assign push = tag_valid_reg[MEM_LATENCY-1] && !redirect;
    assign pop  = (count_reg != '0) && bus.out_ready && !redirect;

    always_comb begin
        count_next      = count_reg + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_next     = rd_ptr_reg + PTR_W'(pop);
        wr_ptr_next     = wr_ptr_reg + PTR_W'(push);
        head_instr_next = fifo_instr_reg[rd_ptr_next];
        head_pc_next    = fifo_pc_reg[rd_ptr_next];
        if (push && (wr_ptr_reg == rd_ptr_next)) begin
            head_instr_next = bus.imem_instr;
            head_pc_next    = tag_addr_reg[MEM_LATENCY-1];
        end
        if (redirect) begin
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
        end
        head_load = !redirect && (count_next != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= RUN;
            pc_reg         <= RESET_PC;
            addr_reg       <= RESET_PC;
            tag_valid_reg  <= '0;
            count_reg      <= '0;
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            head_instr_reg <= '0;
            head_pc_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            addr_reg      <= addr_next;
            tag_valid_reg <= tag_valid_next;
            count_reg     <= count_next;
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            if (head_load) begin
                head_instr_reg <= head_instr_next;
                head_pc_reg    <= head_pc_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_addr_reg <= tag_addr_next;
        if (push) begin
            fifo_instr_reg[wr_ptr_reg] <= bus.imem_instr;
            fifo_pc_reg[wr_ptr_reg]    <= tag_addr_reg[MEM_LATENCY-1];
        end
    end

    assign bus.imem_addr = addr_reg;
    assign bus.out_valid = (count_reg != '0);
    assign bus.out_instr = head_instr_reg;
    assign bus.out_pc    = head_pc_reg;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched_reg;
    logic [15:0] perf_flushed_reg;
    logic [16:0] fetched_sum;
    logic [16:0] flushed_sum;

    assign fetched_sum = {1'b0, perf_fetched_reg} + 17'(push);
    assign flushed_sum = {1'b0, perf_flushed_reg} + 17'(occupancy);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_reg <= '0;
            perf_flushed_reg <= '0;
        end else begin
            if (push) begin
                perf_fetched_reg <= fetched_sum[16] ? 16'hFFFF : fetched_sum[15:0];
            end
            if (redirect) begin
                perf_flushed_reg <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
            end
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_flushed = perf_flushed_reg;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench: two fetch units (RESET_PC 0x00 and 0xF8) against a 2-edge-latency memory model.
// Stimulus queues expected PCs; negedge monitors pop and compare every accepted instruction.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    logic rst_b;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(8), .INSTR_W(32)) if_a ();
    instr_fetch_unit_if #(.ADDR_W(8), .INSTR_W(32)) if_b ();

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched_a, perf_flushed_a, perf_fetched_b, perf_flushed_b;
`endif

    instr_fetch_unit #(
        .ADDR_W(8), .INSTR_W(32), .RESET_PC(8'h00), .PC_STEP(4), .FIFO_DEPTH(4), .MEM_LATENCY(2)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(if_a)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched_a), .perf_flushed(perf_flushed_a)
`endif
    );

    instr_fetch_unit #(
        .ADDR_W(8), .INSTR_W(32), .RESET_PC(8'hF8), .PC_STEP(4), .FIFO_DEPTH(4), .MEM_LATENCY(2)
    ) dut_b (
        .clk(clk), .rst(rst_b), .bus(if_b)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched_b), .perf_flushed(perf_flushed_b)
`endif
    );

    // Word k lives at byte address 4k.
    function automatic logic [31:0] word_at(input logic [7:0] a);
        return 32'h1000_0000 + 32'(a >> 2);
    endfunction

    // One register stage here plus the DUT's address register gives the 2-edge latency.
    logic [31:0] mem_q_a, mem_q_b;
    always @(posedge clk) begin
        mem_q_a <= word_at(if_a.imem_addr);
        mem_q_b <= word_at(if_b.imem_addr);
    end
    assign if_a.imem_instr = mem_q_a;
    assign if_b.imem_instr = mem_q_b;

    int n_cmp = 0;
    int n_err = 0;
    int n_deliv_a = 0;
    int n_deliv_b = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_a(input logic [7:0] start, input int n);
        exp_a.delete();
        for (int i = 0; i < n; i++) exp_a.push_back(start + 8'(4 * i));
    endtask

    task automatic load_b(input logic [7:0] start, input int n);
        exp_b.delete();
        for (int i = 0; i < n; i++) exp_b.push_back(start + 8'(4 * i));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && !if_a.redirect_valid && if_a.out_valid === 1'b1 && if_a.out_ready) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected_delivery", 32'(if_a.out_pc), 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                e = exp_a.pop_front();
                $display("[a] deliver pc=0x%02h instr=0x%08h", if_a.out_pc, if_a.out_instr);
                check("a_out_pc", 32'(if_a.out_pc), 32'(e));
                check("a_out_instr", if_a.out_instr, word_at(e));
                n_deliv_a++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && !if_b.redirect_valid && if_b.out_valid === 1'b1 && if_b.out_ready) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_delivery", 32'(if_b.out_pc), 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                e = exp_b.pop_front();
                $display("[b] deliver pc=0x%02h instr=0x%08h", if_b.out_pc, if_b.out_instr);
                check("b_out_pc", 32'(if_b.out_pc), 32'(e));
                check("b_out_instr", if_b.out_instr, word_at(e));
                n_deliv_b++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // RESET_PC=0xF8 instance: PC wraps through 0x00.
    initial begin
        rst_b = 1'b1;
        if_b.fetch_en = 1'b0; if_b.out_ready = 1'b0;
        if_b.redirect_valid = 1'b0; if_b.redirect_pc = 8'h00;
        step(1);
        check("b_reset_imem_addr", 32'(if_b.imem_addr), 32'hF8);
        rst_b = 1'b0; if_b.fetch_en = 1'b1; if_b.out_ready = 1'b1;
        load_b(8'hF8, 64);
        step(3);
        check("b_first_valid", 32'(if_b.out_valid), 32'h1);
        check("b_first_pc", 32'(if_b.out_pc), 32'hF8);
        step(17);
        if_b.fetch_en = 1'b0;
    end

    initial begin
        int d0;
        rst = 1'b1;
        if_a.fetch_en = 1'b0; if_a.out_ready = 1'b0;
        if_a.redirect_valid = 1'b0; if_a.redirect_pc = 8'h00;
        step(1);
        check("reset_imem_addr", 32'(if_a.imem_addr), 32'h00);
        check("reset_out_valid", 32'(if_a.out_valid), 32'h0);
        check("reset_out_pc", 32'(if_a.out_pc), 32'h00);
        check("reset_out_instr", if_a.out_instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("reset_perf_fetched", 32'(perf_fetched_a), 32'h0);
        check("reset_perf_flushed", 32'(perf_flushed_a), 32'h0);
`endif

        // Streaming: first instruction after edge 3, then one per cycle.
        rst = 1'b0; if_a.fetch_en = 1'b1; if_a.out_ready = 1'b1;
        load_a(8'h00, 64);
        step(1);
        check("e1_imem_addr", 32'(if_a.imem_addr), 32'h00);
        check("e1_out_valid", 32'(if_a.out_valid), 32'h0);
        step(1);
        check("e2_imem_addr", 32'(if_a.imem_addr), 32'h04);
        check("e2_out_valid", 32'(if_a.out_valid), 32'h0);
        step(1);
        check("e3_imem_addr", 32'(if_a.imem_addr), 32'h08);
        check("e3_out_valid", 32'(if_a.out_valid), 32'h1);
        check("e3_out_pc", 32'(if_a.out_pc), 32'h00);
        d0 = n_deliv_a;
        step(8);
        check("throughput_8_cycles", 32'(n_deliv_a - d0), 32'd8);

        // Mid-stream reset with a non-empty FIFO, then stall with out_ready low.
        rst = 1'b1;
        step(1);
        check("midrst_out_valid", 32'(if_a.out_valid), 32'h0);
        check("midrst_imem_addr", 32'(if_a.imem_addr), 32'h00);
        check("midrst_out_pc", 32'(if_a.out_pc), 32'h00);
        check("midrst_out_instr", if_a.out_instr, 32'h0);
        rst = 1'b0; if_a.out_ready = 1'b0;
        load_a(8'h00, 64);
        step(10);
        check("stall_imem_addr", 32'(if_a.imem_addr), 32'h0C);
        check("stall_out_valid", 32'(if_a.out_valid), 32'h1);
        check("stall_head_pc", 32'(if_a.out_pc), 32'h00);
        check("stall_head_instr", if_a.out_instr, word_at(8'h00));
`ifdef FETCH_PERF_CNT_EN
        check("stall_perf_fetched", 32'(perf_fetched_a), 32'd4);
`endif
        if_a.out_ready = 1'b1;
        step(1);
        check("release_no_issue_yet", 32'(if_a.imem_addr), 32'h0C);
        step(1);
        check("release_resume_addr", 32'(if_a.imem_addr), 32'h10);
        step(6);

        // Redirect with 2 buffered and 2 in flight.
        rst = 1'b1;
        step(1);
        rst = 1'b0; if_a.out_ready = 1'b0;
        load_a(8'h00, 64);
        step(4);
        if_a.redirect_valid = 1'b1; if_a.redirect_pc = 8'h40; if_a.out_ready = 1'b1;
        load_a(8'h40, 64);
        step(1);
        if_a.redirect_valid = 1'b0;
        check("redir_out_valid", 32'(if_a.out_valid), 32'h0);
        check("redir_imem_addr", 32'(if_a.imem_addr), 32'h40);
`ifdef FETCH_PERF_CNT_EN
        check("redir_perf_flushed", 32'(perf_flushed_a), 32'd4);
        check("redir_perf_fetched", 32'(perf_fetched_a), 32'd2);
`endif
        step(1);
        check("redir_e1_out_valid", 32'(if_a.out_valid), 32'h0);
        check("redir_e1_imem_addr", 32'(if_a.imem_addr), 32'h44);
        step(1);
        check("redir_e2_out_valid", 32'(if_a.out_valid), 32'h1);
        check("redir_e2_out_pc", 32'(if_a.out_pc), 32'h40);
        step(8);

        // Redirect plus same-edge pop with fetch_en low, from a full FIFO.
        rst = 1'b1;
        step(1);
        rst = 1'b0; if_a.out_ready = 1'b0;
        exp_a.delete();
        step(6);
        if_a.fetch_en = 1'b0; if_a.out_ready = 1'b1;
        if_a.redirect_valid = 1'b1; if_a.redirect_pc = 8'h80;
        step(1);
        if_a.redirect_valid = 1'b0;
        check("redir_noen_out_valid", 32'(if_a.out_valid), 32'h0);
        check("redir_noen_imem_addr", 32'(if_a.imem_addr), 32'h80);
`ifdef FETCH_PERF_CNT_EN
        check("redir_noen_perf_flushed", 32'(perf_flushed_a), 32'd4);
        check("redir_noen_perf_fetched", 32'(perf_fetched_a), 32'd4);
`endif
        step(4);
        check("idle_out_valid", 32'(if_a.out_valid), 32'h0);
        check("idle_imem_addr", 32'(if_a.imem_addr), 32'h80);
        if_a.fetch_en = 1'b1;
        load_a(8'h84, 64);
        step(1);
        check("resume_imem_addr", 32'(if_a.imem_addr), 32'h84);
        step(2);
        check("resume_out_valid", 32'(if_a.out_valid), 32'h1);
        check("resume_out_pc", 32'(if_a.out_pc), 32'h84);
        step(5);

        check("b_delivered_at_least_4", 32'(n_deliv_b >= 4), 32'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
